clk_div_gen: RTL and testbench
==============================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning the number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_WIDTH, default 8, meaning the width of each divide ratio D.
REQ-003 SHALL have parameter DEFAULT_DIV, default 2, meaning the active ratio of every channel after reset (0..2^DIV_WIDTH-1).
REQ-004 SHALL have port clock, input, width 1: the single clock, with all state on its rising edge.
REQ-005 SHALL have port reset_n, input, width 1: asynchronous, active-low reset.
REQ-006 SHALL have port ce, input, width CHANNELS: per-channel count enable.
REQ-007 SHALL have port clr, input, width CHANNELS: per-channel synchronous phase clear.
REQ-008 SHALL have port div_value, input, width CHANNELS*DIV_WIDTH: new ratio, with channel i at bits [i*DIV_WIDTH +: DIV_WIDTH].
REQ-009 SHALL have port div_load, input, width CHANNELS: one-cycle strobe that captures div_value[i] into the shadow register.
REQ-010 SHALL have port div_out, output, width CHANNELS: registered divided waveform.
REQ-011 SHALL have port tick, output, width CHANNELS: registered one-cycle pulse at each period start.
REQ-012 SHALL have port load_pending, output, width CHANNELS: high while the shadow ratio is not yet applied.

Function
REQ-013 Each channel SHALL hold active ratio D, shadow ratio S, pending flag P and counter C (0..D-1, DIV_WIDTH bits).
REQ-014 D=0 SHALL mean channel off: C held at 0, and div_out and tick held at 0.
REQ-015 With D>=1 and ce=1, C SHALL advance by 1 each cycle and wrap from D-1 to 0; with ce=0, C SHALL hold.
REQ-016 div_out SHALL be registered as (ce=1 and C_next >= floor(D/2)): low for floor(D/2) cycles, then high for ceil(D/2) cycles; D=1 gives constant 1.
REQ-017 tick SHALL be high for exactly one cycle following each wrap to C=0 with ce=1, and every cycle when D=1.
REQ-018 ce=0 SHALL force div_out and tick to 0 on the next cycle; re-asserting ce SHALL resume from the held C without re-phasing.
REQ-019 div_load=1 SHALL write S and set P in the same edge; a load while P=1 SHALL overwrite S, with the last write winning.
REQ-020 With P=1, S SHALL transfer to D and P SHALL clear at the next wrap (C=D-1, ce=1), and C SHALL restart at 0 under the new D.
REQ-021 With P=1 and D=0, the transfer SHALL occur on the cycle after the load.
REQ-022 A div_load coincident with a wrap SHALL apply the newly presented div_value at that wrap.
REQ-023 clr=1 SHALL set C=0 and force div_out and tick to 0 on the next cycle; if P=1 it SHALL also apply S immediately.
REQ-024 clr SHALL have priority over ce and over wrap.
REQ-025 A simultaneous clr and div_load SHALL apply the new div_value immediately.
REQ-026 Channels SHALL be fully independent, with no cross-channel timing coupling.
REQ-027 Latency SHALL be 1 cycle from any input change to the registered outputs.

Reset
REQ-028 On reset_n=0, asynchronously: D=DEFAULT_DIV, S=DEFAULT_DIV, P=0, C=0, div_out=0, tick=0, load_pending=0.
REQ-029 Reset deassertion SHALL be used synchronised externally; the first count SHALL occur on the first edge with reset_n=1 and ce=1.

Structure
REQ-030 A shared package clk_div_pkg SHALL hold the DIV_OFF=0 encoding constant and the default DIV_WIDTH and DEFAULT_DIV values.
REQ-031 The datapath SHALL be one sub-module, clk_div_channel (one counter, shadow register and output registers), instantiated CHANNELS times by a generate loop.
REQ-032 There SHALL be no combinational path from inputs to outputs, and no logic on the clock path.

Verification
REQ-033 Bench SHALL cover: D=8, ce=1 for 24 cycles -> div_out 4 low/4 high, repeating, and tick every 8th cycle, 3 pulses.
REQ-034 Bench SHALL cover: D=5 -> div_out 2 low/3 high, tick period 5; D=1 -> div_out constant 1, tick every cycle.
REQ-035 Bench SHALL cover: D=8, load 3 at C=2 -> load_pending high until C=7 wrap, then period 3 begins at C=0, and no truncated period occurs.
REQ-036 Bench SHALL cover: D=6, ce dropped at C=3 for 5 cycles -> outputs 0, C holds 3, and the count resumes 4,5,0 on re-assertion.
REQ-037 Bench SHALL cover: clr at C=4 with pending S=10 -> next cycle C=0, D=10, load_pending=0; clr+load on the same edge -> the new value is active at once.
REQ-038 Bench SHALL cover: reset_n pulsed low mid-period on all 4 channels with mixed D -> outputs 0 immediately, D=DEFAULT_DIV, and channel 2 driven independently of 0/1/3.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock-divider block.
package clk_div_pkg;

  // A ratio of zero switches a channel off.
  localparam int DIV_OFF         = 0;

  // Default ratio width and power-up ratio.
  localparam int DEF_DIV_WIDTH   = 8;
  localparam int DEF_DEFAULT_DIV = 2;

  // Supported channel count range.
  localparam int MIN_CHANNELS    = 1;
  localparam int MAX_CHANNELS    = 16;

endpackage

// File: rtl/clk_div_gen_if.sv
// Control/status bundle for clk_div_gen: per-channel enables, clears,
// ratio loads, and the divided outputs.
interface clk_div_gen_if #(
  parameter int CHANNELS  = 4,
  parameter int DIV_WIDTH = 8
);

  logic [CHANNELS-1:0]           ce;
  logic [CHANNELS-1:0]           clr;
  logic [CHANNELS*DIV_WIDTH-1:0] div_value;
  logic [CHANNELS-1:0]           div_load;
  logic [CHANNELS-1:0]           div_out;
  logic [CHANNELS-1:0]           tick;
  logic [CHANNELS-1:0]           load_pending;

  // Controller side: drives the controls, observes the outputs.
  modport master (
    output ce,
    output clr,
    output div_value,
    output div_load,
    input  div_out,
    input  tick,
    input  load_pending
  );

  // Divider side: receives the controls, produces the outputs.
  modport slave (
    input  ce,
    input  clr,
    input  div_value,
    input  div_load,
    output div_out,
    output tick,
    output load_pending
  );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: active ratio, shadow ratio with pending flag,
// phase counter, and registered div_out/tick.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 clr,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 div_out,
  output logic                 tick,
  output logic                 load_pending
);

  localparam logic [DIV_WIDTH-1:0] OFF  = DIV_WIDTH'(DIV_OFF);
  localparam logic [DIV_WIDTH-1:0] ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DEFV = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] act_div, act_nxt;
  logic [DIV_WIDTH-1:0] shd_div, shd_nxt, shd_eff;
  logic                 pend, pend_nxt, pend_eff;
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic                 div_out_p1, out_nxt;
  logic                 tick_p1, tick_nxt;
  logic                 is_off, wrap, run_nxt;

  // Next-state: clear beats everything, an off channel only absorbs a
  // pending ratio, otherwise count while enabled and swap ratios at wrap.
  always_comb begin
    shd_eff  = div_load ? div_value : shd_div;
    pend_eff = pend | div_load;
    is_off   = (act_div == OFF);
    wrap     = (cnt == act_div - ONE);
    act_nxt  = act_div;
    shd_nxt  = shd_eff;
    pend_nxt = pend_eff;
    cnt_nxt  = cnt;
    out_nxt  = 1'b0;
    tick_nxt = 1'b0;
    run_nxt  = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
      if (pend_eff) begin
        act_nxt  = shd_eff;
        pend_nxt = 1'b0;
      end
    end else if (is_off) begin
      // A ratio loaded into an off channel lands one cycle later; a second
      // load on that cycle still wins.
      cnt_nxt = '0;
      if (pend) begin
        act_nxt  = shd_eff;
        pend_nxt = 1'b0;
      end
    end else if (ce) begin
      if (wrap) begin
        cnt_nxt = '0;
        if (pend_eff) begin
          act_nxt  = shd_eff;
          pend_nxt = 1'b0;
        end
      end else begin
        cnt_nxt = cnt + ONE;
      end
      // Output phase is judged against the ratio that will be active, so a
      // fresh period starts cleanly under the new ratio.
      run_nxt  = (act_nxt != OFF);
      out_nxt  = run_nxt && (cnt_nxt >= (act_nxt >> 1));
      tick_nxt = run_nxt && wrap;
    end
  end

  // Stage boundary: ratio/counter state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_div    <= DEFV;
      shd_div    <= DEFV;
      pend       <= 1'b0;
      cnt        <= '0;
      div_out_p1 <= 1'b0;
      tick_p1    <= 1'b0;
    end else begin
      act_div    <= act_nxt;
      shd_div    <= shd_nxt;
      pend       <= pend_nxt;
      cnt        <= cnt_nxt;
      div_out_p1 <= out_nxt;
      tick_p1    <= tick_nxt;
    end
  end

  assign div_out      = div_out_p1;
  assign tick         = tick_p1;
  assign load_pending = pend;

endmodule

// File: rtl/clk_div_gen.sv
// Bank of independent programmable clock dividers sharing one clock.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic         clock,
  input  logic         reset_n,
  clk_div_gen_if.slave bus
);

  // One self-contained channel per bit; nothing is shared between them.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clk_div_channel #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock        (clock),
      .reset_n      (reset_n),
      .ce           (bus.ce[g]),
      .clr          (bus.clr[g]),
      .div_load     (bus.div_load[g]),
      .div_value    (bus.div_value[g*DIV_WIDTH +: DIV_WIDTH]),
      .div_out      (bus.div_out[g]),
      .tick         (bus.tick[g]),
      .load_pending (bus.load_pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a ratio/phase model.
module tb_clk_div_gen;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int DEF = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  clk_div_gen_if #(.CHANNELS(NCH), .DIV_WIDTH(W)) bus ();

  clk_div_gen #(.CHANNELS(NCH), .DIV_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural model: ratio, shadow, pending, phase and expected outputs.
  int m_d[NCH], m_s[NCH], m_p[NCH], m_ph[NCH];
  int m_o[NCH], m_t[NCH];

  int n_vec  = 0;
  int n_miss = 0;

  logic [NCH-1:0]   cur_ce, cur_clr, cur_ld;
  logic [NCH*W-1:0] cur_dv;

  logic [31:0] cap_o, cap_t, cap_l;

  task automatic check(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_d[i] = DEF; m_s[i] = DEF; m_p[i] = 0; m_ph[i] = 0;
      m_o[i] = 0;   m_t[i] = 0;
    end
  endtask

  // One clock edge worth of channel behaviour, stated in terms of the
  // period length d and the position in the period.
  task automatic model_edge();
    for (int i = 0; i < NCH; i++) begin
      int  nv;
      bit  ld, pend_now;
      ld       = cur_ld[i];
      nv       = ld ? int'(cur_dv[i*W +: W]) : m_s[i];
      pend_now = (m_p[i] != 0) || ld;
      m_o[i] = 0;
      m_t[i] = 0;
      if (cur_clr[i]) begin
        m_ph[i] = 0;
        if (pend_now) m_d[i] = nv;
        m_p[i] = 0;
      end else if (m_d[i] == 0) begin
        m_ph[i] = 0;
        if (m_p[i] != 0) begin
          m_d[i] = nv; m_p[i] = 0;
        end else begin
          m_p[i] = ld;
        end
      end else if (!cur_ce[i]) begin
        m_p[i] = pend_now;
      end else begin
        if (m_ph[i] + 1 >= m_d[i]) begin
          m_ph[i] = 0;
          if (pend_now) m_d[i] = nv;
          m_p[i] = 0;
          m_t[i] = (m_d[i] != 0);
        end else begin
          m_ph[i] = m_ph[i] + 1;
          m_p[i]  = pend_now;
        end
        // Low for the first d/2 positions, high for the rest.
        m_o[i] = (m_d[i] != 0) && (m_ph[i] >= m_d[i] / 2);
      end
      m_s[i] = nv;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("ch%0d div_out", i), int'(bus.div_out[i]), m_o[i]);
      check($sformatf("ch%0d tick", i), int'(bus.tick[i]), m_t[i]);
      check($sformatf("ch%0d load_pending", i), int'(bus.load_pending[i]), m_p[i]);
    end
  endtask

  // Apply current inputs for one edge, advance the model, compare.
  task automatic step();
    bus.ce        = cur_ce;
    bus.clr       = cur_clr;
    bus.div_load  = cur_ld;
    bus.div_value = cur_dv;
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
    cur_clr = '0;
    cur_ld  = '0;
  endtask

  // Clear channel 0 and load a ratio at once.
  task automatic set_ch0(input int d);
    cur_clr[0]    = 1'b1;
    cur_ld[0]     = 1'b1;
    cur_dv[0 +: W] = W'(d);
    step();
  endtask

  task automatic mid_cycle_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("reset div_out", int'(bus.div_out), 0);
    check("reset tick", int'(bus.tick), 0);
    check("reset load_pending", int'(bus.load_pending), 0);
    model_reset();
    compare_all();
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    cur_ce = '0; cur_clr = '0; cur_ld = '0; cur_dv = '0;
    bus.ce = '0; bus.clr = '0; bus.div_load = '0; bus.div_value = '0;
    model_reset();
    #3;
    check("por div_out", int'(bus.div_out), 0);
    check("por tick", int'(bus.tick), 0);
    check("por load_pending", int'(bus.load_pending), 0);
    #9;
    reset_n = 1'b1;

    // Default ratio 2 on every channel.
    cur_ce = '1;
    step();
    check("def2 out first", int'(bus.div_out), 'hF);
    check("def2 tick first", int'(bus.tick), 0);
    step();
    check("def2 out second", int'(bus.div_out), 0);
    check("def2 tick second", int'(bus.tick), 'hF);

    // Ratio 8: four low, four high, tick every 8th.
    cur_ce = 4'b0001;
    set_ch0(8);
    check("d8 pending after clr+load", int'(bus.load_pending[0]), 0);
    cap_o = '0; cap_t = '0;
    for (int j = 0; j < 24; j++) begin
      step();
      cap_o[j] = bus.div_out[0];
      cap_t[j] = bus.tick[0];
    end
    check("d8 out pattern", int'(cap_o[23:0]), 'h787878);
    check("d8 tick pattern", int'(cap_t[23:0]), 'h808080);

    // Ratio 5: two low, three high.
    set_ch0(5);
    cap_o = '0; cap_t = '0;
    for (int j = 0; j < 10; j++) begin
      step();
      cap_o[j] = bus.div_out[0];
      cap_t[j] = bus.tick[0];
    end
    check("d5 out pattern", int'(cap_o[9:0]), 'h1CE);
    check("d5 tick pattern", int'(cap_t[9:0]), 'h210);

    // Ratio 1: constant high, tick every cycle.
    set_ch0(1);
    cap_o = '0; cap_t = '0;
    for (int j = 0; j < 8; j++) begin
      step();
      cap_o[j] = bus.div_out[0];
      cap_t[j] = bus.tick[0];
    end
    check("d1 out pattern", int'(cap_o[7:0]), 'hFF);
    check("d1 tick pattern", int'(cap_t[7:0]), 'hFF);

    // Ratio 8, load 3 at phase 2: old period finishes, then period 3.
    set_ch0(8);
    step();
    step();
    cap_o = '0; cap_t = '0; cap_l = '0;
    for (int j = 0; j < 12; j++) begin
      if (j == 0) begin
        cur_ld[0] = 1'b1;
        cur_dv[0 +: W] = W'(3);
      end
      step();
      cap_o[j] = bus.div_out[0];
      cap_t[j] = bus.tick[0];
      cap_l[j] = bus.load_pending[0];
    end
    check("d8to3 pending", int'(cap_l[11:0]), 'h01F);
    check("d8to3 out", int'(cap_o[11:0]), 'h6DE);
    check("d8to3 tick", int'(cap_t[11:0]), 'h920);

    // Ratio 6, enable dropped at phase 3 for 5 cycles.
    set_ch0(6);
    for (int j = 0; j < 3; j++) step();
    cap_o = '0; cap_t = '0;
    cur_ce[0] = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (j == 5) cur_ce[0] = 1'b1;
      step();
      cap_o[j] = bus.div_out[0];
      cap_t[j] = bus.tick[0];
    end
    check("ce hold out", int'(cap_o[8:0]), 'h060);
    check("ce hold tick", int'(cap_t[8:0]), 'h080);

    // Clear at phase 4 with 10 pending applies it at once.
    set_ch0(8);
    step();
    cur_ld[0] = 1'b1;
    cur_dv[0 +: W] = W'(10);
    step();
    check("clr pend set", int'(bus.load_pending[0]), 1);
    step();
    step();
    cur_clr[0] = 1'b1;
    step();
    check("clr pend cleared", int'(bus.load_pending[0]), 0);
    check("clr out", int'(bus.div_out[0]), 0);
    cap_o = '0; cap_t = '0;
    for (int j = 0; j < 10; j++) begin
      step();
      cap_o[j] = bus.div_out[0];
      cap_t[j] = bus.tick[0];
    end
    check("d10 out", int'(cap_o[9:0]), 'h1F0);
    check("d10 tick", int'(cap_t[9:0]), 'h200);
    set_ch0(4);
    check("clr+load pending", int'(bus.load_pending[0]), 0);
    cap_o = '0; cap_t = '0;
    for (int j = 0; j < 4; j++) begin
      step();
      cap_o[j] = bus.div_out[0];
      cap_t[j] = bus.tick[0];
    end
    check("d4 out", int'(cap_o[3:0]), 'h6);
    check("d4 tick", int'(cap_t[3:0]), 'h8);

    // Mixed ratios on all channels, channel 2 driven on its own, then reset.
    cur_clr = '1; cur_ld = '1;
    cur_dv  = {8'd2, 8'd7, 8'd5, 8'd3};
    step();
    cur_ce = '1;
    for (int j = 0; j < 6; j++) step();
    cur_ce = 4'b1011;
    for (int j = 0; j < 3; j++) step();
    cur_ce = '1;
    cur_clr[2] = 1'b1;
    step();
    for (int j = 0; j < 4; j++) step();
    mid_cycle_reset();
    step();
    check("post reset out", int'(bus.div_out), 'hF);
    check("post reset tick", int'(bus.tick), 0);
    step();
    check("post reset out 2", int'(bus.div_out), 0);
    check("post reset tick 2", int'(bus.tick), 'hF);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        int r;
        cur_ce[i]  = ($urandom % 8) != 0;
        cur_clr[i] = ($urandom % 40) == 0;
        cur_ld[i]  = ($urandom % 12) == 0;
        r = $urandom % 20;
        if (r < 3)       cur_dv[i*W +: W] = W'($urandom_range(0, 1));
        else if (r == 3) cur_dv[i*W +: W] = W'($urandom % 256);
        else             cur_dv[i*W +: W] = W'($urandom_range(2, 12));
      end
      step();
      if (n % 750 == 749) mid_cycle_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
